// File: rtl/mem_data_req_ctrl_if.sv
// EX/MEM-to-dcache request bundle for the MEM-stage data request controller.
// master = controller side, slave = EX/MEM register plus dcache side.
interface mem_data_req_ctrl_if;
  logic        dREN_EX_MEM;
  logic        dWEN_EX_MEM;
  logic        halt_EX_MEM;
  logic [31:0] dmemaddr_EX_MEM;
  logic [31:0] dmemstore_EX_MEM;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        mem_stall;
  logic [31:0] dmemload_MEM;
  logic        load_valid;
  logic        halt_out;
  logic        timeout_err;

  modport master (
    input  dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, dmemaddr_EX_MEM, dmemstore_EX_MEM,
    input  dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
    output dmemload_MEM, load_valid, halt_out, timeout_err
  );

  modport slave (
    output dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, dmemaddr_EX_MEM, dmemstore_EX_MEM,
    output dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
    input  dmemload_MEM, load_valid, halt_out, timeout_err
  );
endinterface

// File: rtl/mem_data_req_ctrl.sv
// MEM-stage data memory request controller: holds a load/store toward the dcache,
// stalls the pipeline until dhit, captures load data, tracks halt and a wait watchdog.
module mem_data_req_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  mem_data_req_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

  state_t             state_q;
  logic [31:0]        hold_addr_q;
  logic [31:0]        hold_data_q;
  logic               hold_ren_q;
  logic               hold_wen_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout_q;
  logic               halt_q;
  logic [31:0]        load_data_p1;
  logic               vld_p1;

  logic               req;
  logic               active_rd;
  logic               capture;

  assign req     = bus.dREN_EX_MEM | bus.dWEN_EX_MEM;
  assign cnt_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;

  // Request path: live inputs in IDLE, hold registers in WAIT, nothing when halted.
  always_comb begin
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
    bus.mem_stall = 1'b0;
    active_rd     = 1'b0;
    case (state_q)
      IDLE: begin
        bus.dmemREN   = bus.dREN_EX_MEM & ~bus.dWEN_EX_MEM;
        bus.dmemWEN   = bus.dWEN_EX_MEM;
        bus.dmemaddr  = bus.dmemaddr_EX_MEM;
        bus.dmemstore = bus.dmemstore_EX_MEM;
        bus.mem_stall = req & ~bus.dhit;
        active_rd     = bus.dREN_EX_MEM & ~bus.dWEN_EX_MEM;
      end
      WAIT: begin
        bus.dmemREN   = hold_ren_q;
        bus.dmemWEN   = hold_wen_q;
        bus.dmemaddr  = hold_addr_q;
        bus.dmemstore = hold_data_q;
        bus.mem_stall = ~bus.dhit;
        active_rd     = hold_ren_q;
      end
      HALTED: begin
        bus.mem_stall = 1'b1;
      end
      default: begin
        bus.mem_stall = 1'b0;
      end
    endcase
  end

  assign capture = bus.dhit & active_rd;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      hold_ren_q   <= 1'b0;
      hold_wen_q   <= 1'b0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      halt_q       <= 1'b0;
      load_data_p1 <= '0;
      vld_p1       <= 1'b0;
    end else begin
      // Load capture stage: data and valid land together, aligned with MEM/WB.
      vld_p1 <= capture;
      if (capture) load_data_p1 <= bus.dmemload;

      case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          if (req) begin
            hold_addr_q <= bus.dmemaddr_EX_MEM;
            hold_data_q <= bus.dmemstore_EX_MEM;
            hold_ren_q  <= bus.dREN_EX_MEM & ~bus.dWEN_EX_MEM;
            hold_wen_q  <= bus.dWEN_EX_MEM;
            if (!bus.dhit) state_q <= WAIT;
          end else if (bus.halt_EX_MEM) begin
            state_q <= HALTED;
            halt_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.dhit) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= cnt_inc;
            // A hit in the threshold cycle takes the branch above, so it never flags.
            if (cnt_inc >= CNT_W'(TIMEOUT)) timeout_q <= 1'b1;
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.dmemload_MEM = load_data_p1;
  assign bus.load_valid   = vld_p1;
  assign bus.halt_out     = halt_q;
  assign bus.timeout_err  = timeout_q;

endmodule

// File: tb/tb_mem_data_req_ctrl.sv
// Directed bench for mem_data_req_ctrl with a short watchdog (TIMEOUT = 8).
module tb_mem_data_req_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_data_req_ctrl_if bus ();

  mem_data_req_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic wen, input logic halt,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic hit, input logic [31:0] ld);
    bus.dREN_EX_MEM      = ren;
    bus.dWEN_EX_MEM      = wen;
    bus.halt_EX_MEM      = halt;
    bus.dmemaddr_EX_MEM  = addr;
    bus.dmemstore_EX_MEM = data;
    bus.dhit             = hit;
    bus.dmemload         = ld;
  endtask

  // Drive on the falling edge, sample 1 ns later, well ahead of the next rising edge.
  task automatic step(input logic ren, input logic wen, input logic halt,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic hit, input logic [31:0] ld);
    @(negedge CLK);
    drive(ren, wen, halt, addr, data, hit, ld);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ren"},   32'(bus.dmemREN),     32'h0);
    check_val({tag, "_wen"},   32'(bus.dmemWEN),     32'h0);
    check_val({tag, "_addr"},  bus.dmemaddr,         32'h0);
    check_val({tag, "_store"}, bus.dmemstore,        32'h0);
    check_val({tag, "_stall"}, 32'(bus.mem_stall),   32'h0);
    check_val({tag, "_ld"},    bus.dmemload_MEM,     32'h0);
    check_val({tag, "_lv"},    32'(bus.load_valid),  32'h0);
    check_val({tag, "_halt"},  32'(bus.halt_out),    32'h0);
    check_val({tag, "_tmo"},   32'(bus.timeout_err), 32'h0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    check_all_zero("rst");
    @(negedge CLK);
    RST = 1'b0;

    // Load with same-cycle hit
    step(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
    check_val("ld_hit_ren",   32'(bus.dmemREN),   32'h1);
    check_val("ld_hit_stall", 32'(bus.mem_stall), 32'h0);
    check_val("ld_hit_addr",  bus.dmemaddr,       32'h100);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_val("ld_hit_data",  bus.dmemload_MEM,    32'hDEADBEEF);
    check_val("ld_hit_lv",    32'(bus.load_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_val("ld_hit_lv_off", 32'(bus.load_valid), 32'h0);

    // Store with three miss cycles in WAIT, then hit; inputs turn to garbage
    step(1'b0, 1'b1, 1'b0, 32'h200, 32'h12345678, 1'b0, 32'h0);
    check_val("st_issue_stall", 32'(bus.mem_stall), 32'h1);
    check_val("st_issue_wen",   32'(bus.dmemWEN),   32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'hBAD0BAD0, 32'hFFFFFFFF, 1'b0, 32'h0);
      check_val("st_wait_stall", 32'(bus.mem_stall), 32'h1);
      check_val("st_wait_wen",   32'(bus.dmemWEN),   32'h1);
      check_val("st_wait_ren",   32'(bus.dmemREN),   32'h0);
      check_val("st_wait_addr",  bus.dmemaddr,       32'h200);
      check_val("st_wait_data",  bus.dmemstore,      32'h12345678);
    end
    step(1'b1, 1'b0, 1'b0, 32'hBAD0BAD0, 32'hFFFFFFFF, 1'b1, 32'h0000CAFE);
    check_val("st_hit_stall", 32'(bus.mem_stall), 32'h0);
    check_val("st_hit_addr",  bus.dmemaddr,       32'h200);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_val("st_done_lv",   32'(bus.load_valid), 32'h0);
    check_val("st_done_data", bus.dmemload_MEM,    32'hDEADBEEF);
    check_val("st_done_idle", 32'(bus.mem_stall),  32'h0);

    // Both enables high: the write wins, no load capture
    step(1'b1, 1'b1, 1'b0, 32'h300, 32'hA5A5A5A5, 1'b1, 32'h00000055);
    check_val("both_wen",   32'(bus.dmemWEN),   32'h1);
    check_val("both_ren",   32'(bus.dmemREN),   32'h0);
    check_val("both_stall", 32'(bus.mem_stall), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_val("both_lv",   32'(bus.load_valid), 32'h0);
    check_val("both_data", bus.dmemload_MEM,    32'hDEADBEEF);

    // Hit in the 8th WAIT cycle: completion beats the watchdog
    step(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0BADF00D);
    check_val("wd8_hit_stall", 32'(bus.mem_stall), 32'h0);
    check_val("wd8_hit_addr",  bus.dmemaddr,       32'h400);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_val("wd8_tmo",  32'(bus.timeout_err), 32'h0);
    check_val("wd8_lv",   32'(bus.load_valid),  32'h1);
    check_val("wd8_data", bus.dmemload_MEM,     32'h0BADF00D);

    // Read that never hits: error after 8 WAIT cycles, request stays up
    step(1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 1'b0, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      check_val("wd_pre_ren", 32'(bus.dmemREN), 32'h1);
    end
    check_val("wd_pre_tmo", 32'(bus.timeout_err), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_val("wd_tmo",   32'(bus.timeout_err), 32'h1);
    check_val("wd_ren",   32'(bus.dmemREN),     32'h1);
    check_val("wd_stall", 32'(bus.mem_stall),   32'h1);
    check_val("wd_addr",  bus.dmemaddr,         32'h500);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_val("wd_sticky", 32'(bus.timeout_err), 32'h1);
    #2;
    RST = 1'b1;
    #1;
    check_val("wd_rst_tmo", 32'(bus.timeout_err), 32'h0);
    check_val("wd_rst_ren", 32'(bus.dmemREN),     32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // Asynchronous reset during the 2nd WAIT cycle
    step(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_val("mid_pre_ren", 32'(bus.dmemREN), 32'h1);
    #1;
    RST = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge CLK);
    RST = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 1'b1, 32'h00000077);
    check_val("post_rst_ren",   32'(bus.dmemREN),   32'h1);
    check_val("post_rst_stall", 32'(bus.mem_stall), 32'h0);
    check_val("post_rst_addr",  bus.dmemaddr,       32'h700);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_val("post_rst_lv",   32'(bus.load_valid), 32'h1);
    check_val("post_rst_data", bus.dmemload_MEM,    32'h00000077);

    // Halt: sticky, blocks later requests and ignores dhit
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
    check_val("halt_seen_out",   32'(bus.halt_out),  32'h0);
    check_val("halt_seen_stall", 32'(bus.mem_stall), 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h800, 32'h0, 1'b1, 32'h00000088);
    check_val("halted_out",   32'(bus.halt_out),  32'h1);
    check_val("halted_stall", 32'(bus.mem_stall), 32'h1);
    check_val("halted_ren",   32'(bus.dmemREN),   32'h0);
    check_val("halted_addr",  bus.dmemaddr,       32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_val("halted_lv",   32'(bus.load_valid), 32'h0);
    check_val("halted_data", bus.dmemload_MEM,    32'h00000077);
    check_val("halted_hold", 32'(bus.halt_out),   32'h1);
    RST = 1'b1;
    #1;
    check_val("halt_rst_out",   32'(bus.halt_out),  32'h0);
    check_val("halt_rst_stall", 32'(bus.mem_stall), 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_data_req_ctrl.md
# mem_data_req_ctrl

MEM-stage data memory request controller: the consumer of the EX/MEM pipeline register outputs. It turns the registered memory-access fields into a held read or write request toward the data cache, and stalls the pipeline until the cache acknowledges with `dhit`. It captures load data, tracks the halt instruction to a sticky halted state, and flags a stuck request with a watchdog. It sits between the EX/MEM register and the dcache port, and its `mem_stall` feeds the hazard unit's enable/flush logic.

## Interface
Parameters:
- `TIMEOUT`, 1024: cycles in WAIT without `dhit` before `timeout_err` sets.
- `CNT_W`, 16: wait-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `dREN_EX_MEM` in 1: instruction in MEM is a load.
- `dWEN_EX_MEM` in 1: instruction in MEM is a store.
- `halt_EX_MEM` in 1: instruction in MEM is halt.
- `dmemaddr_EX_MEM` in 32: data address.
- `dmemstore_EX_MEM` in 32: store data.
- `dhit` in 1: cache acknowledges the current request this cycle.
- `dmemload` in 32: cache read data, valid when `dhit`.
- `dmemREN` out 1: read request to cache.
- `dmemWEN` out 1: write request to cache.
- `dmemaddr` out 32: request address.
- `dmemstore` out 32: request write data.
- `mem_stall` out 1: freeze EX/MEM and earlier stages, and bubble MEM/WB.
- `dmemload_MEM` out 32: registered load data.
- `load_valid` out 1: one-cycle pulse when `dmemload_MEM` updates.
- `halt_out` out 1: sticky processor-halted flag.
- `timeout_err` out 1: sticky watchdog error.

## Operation
- States: IDLE, WAIT, HALTED.
- Request decode: `req = dREN_EX_MEM | dWEN_EX_MEM`. If both are asserted, the write wins and `dmemREN` is forced to 0.
- **IDLE:**
  - Drive `dmemREN`/`dmemWEN`/`dmemaddr`/`dmemstore` combinationally from the EX/MEM inputs.
  - Latch addr/data/type into hold registers on every cycle where `req` is asserted.
  - `req & dhit`: access completes this cycle, `mem_stall`=0, stay in IDLE.
  - `req & !dhit`: `mem_stall`=1, go to WAIT.
  - `!req & halt_EX_MEM`: go to HALTED.
  - `req & halt_EX_MEM`: halt is ignored; decoder never produces this combination.
- **WAIT:**
  - Drive request outputs from the hold registers; input changes are ignored.
  - `mem_stall`=1 until `dhit`.
  - On `dhit`: `mem_stall`=0 that same cycle, go to IDLE.
  - Wait counter increments each WAIT cycle and saturates at all-ones.
  - When the count reaches `TIMEOUT` without `dhit`, `timeout_err` sets. The request stays asserted and the state stays WAIT.
- **HALTED:**
  - Request outputs are 0 and `mem_stall`=1.
  - `halt_out`=1.
  - Leave only on reset.
- Load capture: on any cycle with `dhit` and an active read, `dmemload_MEM` is loaded from `dmemload` and `load_valid` pulses the next cycle. Write completions do not update `dmemload_MEM`.
- The wait counter clears on entry to IDLE.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - All outputs 0, including `dmemaddr`/`dmemstore` and hold registers.
  - Wait counter 0.
  - Exception: request outputs are combinational in IDLE, so they follow the inputs after reset. With inputs low they are 0.
- Hit latency:
  - Same-cycle `dhit`: 0 stall cycles.
  - `dhit` after N WAIT cycles: `mem_stall` is high for exactly N+1 cycles (the issue cycle plus N).
- `load_valid`/`dmemload_MEM` appear one cycle after the `dhit` edge, aligned with MEM/WB outputs.
- `halt_out` rises one cycle after halt is seen in IDLE.
- `timeout_err` rises on the edge ending the `TIMEOUT`-th consecutive WAIT cycle. It is sticky until `RST`.
- A `dhit` arriving in the same cycle as the timeout threshold: completion wins and `timeout_err` does not set.
- `dhit` while not requesting (IDLE with no `req`, or HALTED) is ignored: no capture, no pulse.
- Reset asserted mid-WAIT:
  - Request drops immediately and the state returns to IDLE.
  - The pending access is abandoned.
  - `timeout_err` and `halt_out` clear.

## Test plan
- **Load, immediate hit:** `dREN`=1, addr 0x100, `dhit`=1 with `dmemload`=0xDEADBEEF in the same cycle -> `dmemREN`=1, `mem_stall`=0; next cycle `dmemload_MEM`=0xDEADBEEF and `load_valid`=1 for one cycle.
- **Store, 3-cycle miss:** `dWEN`=1, addr 0x200, data 0x12345678, `dhit` on the 4th cycle. Inputs change to garbage after cycle 1.
  - Expected: `mem_stall` high for 4 cycles; `dmemaddr`/`dmemstore` hold 0x200/0x12345678 throughout; `load_valid` stays 0.
- **Halt:** `halt_EX_MEM`=1 with no request -> `halt_out`=1 and `mem_stall`=1 the next cycle. A following `dREN` produces no `dmemREN`. Only `RST` clears the state.
- **Watchdog:** with `TIMEOUT`=8, issue a read and never assert `dhit`.
  - Expected: `timeout_err` rises after 8 WAIT cycles while `dmemREN` stays 1.
  - Variant: `dhit` on exactly the 8th cycle -> no error.
- **Reset mid-WAIT:** assert `RST` asynchronously (between clock edges) during the 2nd WAIT cycle -> all outputs 0 immediately; after release the block is IDLE and a new read completes normally.
- **Both enables high:** `dREN`=`dWEN`=1 -> `dmemWEN`=1, `dmemREN`=0; on completion no load capture.
